// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, condition codes, flag bit positions,
// halt state encoding and the B-type target helper.
// Imported by the branch resolver and any future flag consumer.
package wisc_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_t;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

  // PC-relative target: offset is in words, so shift left by one; wraps mod 2^16.
  function automatic logic [15:0] b_target(input logic [15:0] pc_plus2,
                                           input logic [8:0]  imm9);
    return pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolver bus: ID instruction fields and flag state in,
// branch decision, flush/stall strobes, halt status and counters out.
// master = pipeline side driving ID fields; slave = resolver.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_opcode;
  logic [2:0]       id_cond;
  logic [8:0]       id_imm9;
  logic [15:0]      id_rs_data;
  logic [15:0]      id_pc_plus2;
  logic [2:0]       flags;
  logic [2:0]       ex_flag_en;
  logic             take_branch;
  logic [15:0]      branch_target;
  logic             flush_if;
  logic             stall_id;
  logic             halted;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_valid, id_opcode, id_cond, id_imm9, id_rs_data, id_pc_plus2,
           flags, ex_flag_en,
    input  take_branch, branch_target, flush_if, stall_id, halted,
           br_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_cond, id_imm9, id_rs_data, id_pc_plus2,
           flags, ex_flag_en,
    output take_branch, branch_target, flush_if, stall_id, halted,
           br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Condition evaluator: decides a condition code against Z/N/V and reports
// which flag bits that decision depends on. Purely combinational, no stall.
// Ports: cond (code), flags ([2]=V,[1]=N,[0]=Z) -> cond_true, need_mask.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  cond_t      cond,
  input  logic [2:0] flags,
  output logic       cond_true,
  output logic [2:0] need_mask
);

  logic w_z, w_n, w_v;
  assign w_z = flags[FLAG_Z];
  assign w_n = flags[FLAG_N];
  assign w_v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    need_mask = 3'b000;
    case (cond)
      COND_NE: begin cond_true = ~w_z;                     need_mask[FLAG_Z] = 1'b1; end
      COND_EQ: begin cond_true = w_z;                      need_mask[FLAG_Z] = 1'b1; end
      COND_GT: begin
        cond_true = ~w_z & ~w_n;
        need_mask[FLAG_Z] = 1'b1;
        need_mask[FLAG_N] = 1'b1;
      end
      COND_LT: begin cond_true = w_n;                      need_mask[FLAG_N] = 1'b1; end
      COND_GE: begin
        cond_true = w_z | (~w_z & ~w_n);
        need_mask[FLAG_Z] = 1'b1;
        need_mask[FLAG_N] = 1'b1;
      end
      COND_LE: begin
        cond_true = w_n | w_z;
        need_mask[FLAG_Z] = 1'b1;
        need_mask[FLAG_N] = 1'b1;
      end
      COND_OV: begin cond_true = w_v;                      need_mask[FLAG_V] = 1'b1; end
      default: begin cond_true = 1'b1; end  // always: depends on no flag
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver + HLT drain/halt FSM + saturating branch counters.
// Decision/target/flush/stall are same-cycle; one-cycle stall on a flag hazard.
// Ports: clk, rst (sync, active-high), bus (slave modport of branch_resolve_unit_if).
module branch_resolve_unit
  import wisc_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic                    clk,
  input logic                    rst,
  branch_resolve_unit_if.slave   bus
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  halt_state_t      r_state;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_stall_q;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic        w_run, w_is_br, w_is_hlt, w_hazard, w_resolve, w_taken;
  logic        w_cond_true;
  logic [2:0]  w_need_mask;
  logic [15:0] w_target;

  branch_cond_eval u_cond (
    .cond      (cond_t'(bus.id_cond)),
    .flags     (bus.flags),
    .cond_true (w_cond_true),
    .need_mask (w_need_mask)
  );

  assign w_run    = (r_state == ST_RUN) & ~rst;
  assign w_is_br  = bus.id_valid & ((bus.id_opcode == OP_B) | (bus.id_opcode == OP_BR));
  assign w_is_hlt = bus.id_valid & (bus.id_opcode == OP_HLT);

  // A flag the condition reads is being rewritten in EX: wait one cycle.
  // r_stall_q masks the second look so a branch never stalls twice.
  assign w_hazard  = w_run & w_is_br & (|(bus.ex_flag_en & w_need_mask)) & ~r_stall_q;
  assign w_resolve = w_run & w_is_br & ~w_hazard;
  assign w_taken   = w_resolve & w_cond_true;
  assign w_target  = (bus.id_opcode == OP_BR) ? bus.id_rs_data
                                              : b_target(bus.id_pc_plus2, bus.id_imm9);

  assign bus.take_branch   = w_taken;
  assign bus.branch_target = w_taken ? w_target : 16'h0000;
  assign bus.flush_if      = w_taken;
  assign bus.stall_id      = ~rst & ((r_state != ST_RUN) | w_hazard);
  assign bus.halted        = ~rst & (r_state == ST_HALTED);
  assign bus.br_cnt        = r_br_cnt;
  assign bus.taken_cnt     = r_taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_stall_q   <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_stall_q <= w_hazard;
      if (w_resolve && (r_br_cnt != {CNT_W{1'b1}}))
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_taken && (r_taken_cnt != {CNT_W{1'b1}}))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);

      case (r_state)
        ST_RUN: begin
          if (w_is_hlt) begin
            r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
            r_state     <= (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Count reaches 0 on the same edge that enters HALTED.
          r_drain_cnt <= r_drain_cnt - DW'(1);
          if (r_drain_cnt <= DW'(1))
            r_state <= ST_HALTED;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected
// per-cycle outputs from a behavioural model, plus a narrow-counter
// instance for saturation.
module tb_branch_resolve_unit;
  import wisc_pkg::*;

  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(16)) bif ();
  branch_resolve_unit_if #(.CNT_W(4))  sif ();

  branch_resolve_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bif)
  );
  branch_resolve_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_s (
    .clk (clk), .rst (rst_s), .bus (sif)
  );

  typedef struct {
    logic        take;
    logic [15:0] tgt;
    logic        flush;
    logic        stall;
    logic        halted;
    logic [15:0] br;
    logic [15:0] tk;
  } exp_t;

  exp_t sb_q[$];
  int   sat_q[$];

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int m_mode;   // 0 run, 1 drain, 2 halted
  int m_left;
  bit m_sq;
  int m_br, m_tk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] c, input logic [2:0] f);
    bit z, n, v;
    z = f[0]; n = f[1]; v = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] ref_mask(input logic [2:0] c);
    case (c)
      3'd0, 3'd1:       return 3'b001;
      3'd2, 3'd4, 3'd5: return 3'b011;
      3'd3:             return 3'b010;
      3'd6:             return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_sq = 1'b0; m_br = 0; m_tk = 0;
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bif.id_valid = 1'b0;
    model_reset();
  endtask

  // One ID cycle: drive, push the expected outputs, advance the model, then compare at negedge.
  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] c,
                       input logic [8:0] imm, input logic [15:0] rs, input logic [15:0] pc,
                       input logic [2:0] fl, input logic [2:0] en);
    exp_t e, g;
    bit run, isbr, ishlt, hz, res, tk;
    logic signed [8:0] simm;
    int full;
    logic [31:0] fullv;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.id_valid = v; bif.id_opcode = op; bif.id_cond = c; bif.id_imm9 = imm;
    bif.id_rs_data = rs; bif.id_pc_plus2 = pc; bif.flags = fl; bif.ex_flag_en = en;

    run   = (m_mode == 0);
    isbr  = v && (op == OP_B || op == OP_BR);
    ishlt = v && (op == OP_HLT);
    hz    = run && isbr && ((en & ref_mask(c)) != 3'b000) && !m_sq;
    res   = run && isbr && !hz;
    tk    = res && ref_cond(c, fl);
    simm  = imm;
    full  = int'(pc) + int'(simm) * 2;
    fullv = full;
    e.take   = tk;
    e.tgt    = !tk ? 16'h0000 : (op == OP_BR) ? rs : fullv[15:0];
    e.flush  = tk;
    e.stall  = !run || hz;
    e.halted = (m_mode == 2);
    e.br     = m_br[15:0];
    e.tk     = m_tk[15:0];
    sb_q.push_back(e);

    m_sq = hz;
    if (res && m_br != 16'hFFFF) m_br++;
    if (tk && m_tk != 16'hFFFF) m_tk++;
    if (run && ishlt) begin
      m_left = DRAIN - 1;
      m_mode = (m_left == 0) ? 2 : 1;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end

    @(negedge clk);
    check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      g = sb_q.pop_front();
      check_val("take_branch",   32'(bif.take_branch),   32'(g.take));
      check_val("branch_target", 32'(bif.branch_target), 32'(g.tgt));
      check_val("flush_if",      32'(bif.flush_if),      32'(g.flush));
      check_val("stall_id",      32'(bif.stall_id),      32'(g.stall));
      check_val("halted",        32'(bif.halted),        32'(g.halted));
      check_val("br_cnt",        32'(bif.br_cnt),        32'(g.br));
      check_val("taken_cnt",     32'(bif.taken_cnt),     32'(g.tk));
    end
  endtask

  task automatic bubble();
    drive(1'b0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    bif.id_valid = 1'b0; bif.id_opcode = 4'h0; bif.id_cond = 3'd0; bif.id_imm9 = 9'h0;
    bif.id_rs_data = 16'h0; bif.id_pc_plus2 = 16'h0; bif.flags = 3'b000; bif.ex_flag_en = 3'b000;
    sif.id_valid = 1'b0; sif.id_opcode = 4'h0; sif.id_cond = 3'd0; sif.id_imm9 = 9'h0;
    sif.id_rs_data = 16'h0; sif.id_pc_plus2 = 16'h0; sif.flags = 3'b000; sif.ex_flag_en = 3'b000;
    model_reset();
    reset_cycle();
    reset_cycle();

    // reset state
    bubble();

    // B EQ taken, forward offset
    drive(1'b1, OP_B, COND_EQ, 9'h004, 16'h0, 16'h0010, 3'b001, 3'b000);
    // B LT with N being rewritten: stall once, then taken backwards
    drive(1'b1, OP_B, COND_LT, 9'h1FE, 16'h0, 16'h0010, 3'b000, 3'b011);
    drive(1'b1, OP_B, COND_LT, 9'h1FE, 16'h0, 16'h0010, 3'b010, 3'b000);
    // B OV while only Z is written: no stall, not taken
    drive(1'b1, OP_B, COND_OV, 9'h010, 16'h0, 16'h0100, 3'b000, 3'b001);
    // BR always, all flags being written: no dependency
    drive(1'b1, OP_BR, COND_UN, 9'h000, 16'hBEEF, 16'h0200, 3'b000, 3'b111);
    // B target wraps
    drive(1'b1, OP_B, COND_UN, 9'h001, 16'h0, 16'hFFFE, 3'b000, 3'b000);
    // hazard persists on second look: stall only once
    drive(1'b1, OP_B, COND_GT, 9'h008, 16'h0, 16'h0040, 3'b000, 3'b010);
    drive(1'b1, OP_B, COND_GT, 9'h008, 16'h0, 16'h0040, 3'b000, 3'b010);
    // non-branch opcode with hazardous flag enables
    drive(1'b1, 4'b0010, COND_EQ, 9'h004, 16'h0, 16'h0010, 3'b001, 3'b111);
    bubble();

    // mixed traffic
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      int r;
      r = $urandom_range(0, 3);
      op = (r == 1) ? OP_BR : (r == 2) ? 4'b0010 : OP_B;
      drive(($urandom_range(0, 7) != 0), op, 3'($urandom_range(0, 7)),
            9'($urandom), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    end

    // HLT: drain, then halted and absorbing; branches ignored meanwhile
    drive(1'b1, OP_HLT, COND_EQ, 9'h0, 16'h0, 16'h0, 3'b000, 3'b000);
    drive(1'b1, OP_B, COND_UN, 9'h004, 16'h0, 16'h0010, 3'b001, 3'b111);
    bubble();
    drive(1'b1, OP_BR, COND_UN, 9'h0, 16'h1234, 16'h0, 3'b000, 3'b000);
    bubble();
    bubble();
    drive(1'b1, OP_B, COND_EQ, 9'h004, 16'h0, 16'h0010, 3'b001, 3'b000);

    // reset mid-drain returns to RUN with cleared counters
    reset_cycle();
    drive(1'b1, OP_B, COND_UN, 9'h002, 16'h0, 16'h0020, 3'b000, 3'b000);
    drive(1'b1, OP_BR, COND_UN, 9'h0, 16'h0300, 16'h0, 3'b000, 3'b000);
    drive(1'b1, OP_HLT, COND_UN, 9'h0, 16'h0, 16'h0, 3'b000, 3'b000);
    bubble();
    reset_cycle();
    bubble();
    drive(1'b1, OP_B, COND_NE, 9'h003, 16'h0, 16'h0050, 3'b000, 3'b000);
    bubble();

    // narrow-counter instance: both counters saturate at all-ones
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    sif.id_valid = 1'b1; sif.id_opcode = OP_BR; sif.id_cond = COND_UN; sif.id_rs_data = 16'h0400;
    for (int i = 0; i < 20; i++) begin
      sat_q.push_back((i > 15) ? 15 : i);
      @(negedge clk);
      if (sat_q.size() != 0) begin
        int ex;
        ex = sat_q.pop_front();
        check_val("sat_br_cnt",    32'(sif.br_cnt),    32'(ex));
        check_val("sat_taken_cnt", 32'(sif.taken_cnt), 32'(ex));
      end
      @(posedge clk);
      #1;
    end
    sif.id_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage control-flow resolver for the 16-bit WISC pipeline; the reader of the Z/N/V flag register that the execute-stage ALU writes.
- Evaluates B/BR conditions against the registered flags and interlocks against an in-flight flag write.
- Produces the taken decision, target PC and IF flush; runs the HLT drain/halt state machine; keeps branch statistics counters.

Parameters:
DRAIN_CYCLES, 4, cycles from HLT leaving ID until halted asserts (drains EX/MEM/WB)
CNT_W, 16, width of branch statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction (0 = bubble)
id_opcode  in  4  ID opcode; B=4'b1100, BR=4'b1101, HLT=4'b1111
id_cond  in  3  branch condition code, instr[11:9]
id_imm9  in  9  B offset, signed, in words
id_rs_data  in  16  BR target register value
id_pc_plus2  in  16  PC of ID instruction + 2
flags  in  3  registered ALU flags; [2]=V, [1]=N, [0]=Z
ex_flag_en  in  3  per-bit flag write enables of the instruction in EX this cycle
take_branch  out  1  branch taken this cycle
branch_target  out  16  next PC when take_branch=1, else 0
flush_if  out  1  squash instruction in IF
stall_id  out  1  hold PC and IF/ID, insert bubble into EX
halted  out  1  processor halted
br_cnt  out  CNT_W  resolved B/BR count
taken_cnt  out  CNT_W  taken B/BR count

Behaviour:
- Reset: every output 0; FSM=RUN; stall_q=0; counters 0. Reset during DRAIN or HALTED also returns to RUN.
- is_br = id_valid & (opcode==B | opcode==BR). take_branch, branch_target, flush_if and stall_id are combinational, same cycle.
- Condition codes:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- Needed-flag mask:
  - NE/EQ: Z only
  - GT/GE/LE: Z|N
  - LT: N only
  - OV: V only
  - always: none
- Flag interlock:
  - hazard = is_br & ((ex_flag_en & mask) != 0) & ~stall_q. When hazard: stall_id=1, take_branch=0, counters unchanged.
  - stall_q is set to hazard each cycle, which guarantees at most one stall per branch; the next cycle sees updated flags.
- Resolution (is_br & ~hazard, FSM=RUN):
  - Evaluate the condition against flags.
  - B target = id_pc_plus2 + (sext(id_imm9) << 1), modulo 2^16 (wraps).
  - BR target = id_rs_data.
  - If taken: take_branch=1, flush_if=1.
  - br_cnt increments; taken_cnt increments if taken. Both saturate at all-ones.
- Halt FSM (RUN, DRAIN, HALTED):
  - RUN -> DRAIN when id_valid & opcode==HLT; drain counter loads DRAIN_CYCLES-1.
  - DRAIN decrements each cycle; at 0 -> HALTED.
  - HALTED is absorbing until rst; halted=1 only in HALTED.
  - In DRAIN and HALTED: stall_id=1, take_branch=0, flush_if=0, counters frozen.
  - Flag writes from draining instructions are ignored.
- A non-branch, non-HLT opcode, or id_valid=0: all strobes 0, no state change except stall_q<=0.
- id_cond is ignored for HLT.

Decomposition:
- Shared package wisc_pkg:
  - opcode localparams (B, BR, HLT)
  - cond_t enum (NE, EQ, GT, LT, GE, LE, OV, UN)
  - flag bit indices FLAG_V=2, FLAG_N=1, FLAG_Z=0
  - halt_state_t enum
- Sub-module branch_cond_eval: combinational; inputs cond and flags; outputs cond_true and need_mask. Reused by any future flag consumer.

Test Plan:
1. B EQ, flags=001, ex_flag_en=0, pc_plus2=0x0010, imm9=0x004 -> take_branch=1, target=0x0018, flush_if=1, br_cnt=1, taken_cnt=1.
2. B LT, imm9=0x1FE (-2), pc_plus2=0x0010, ex_flag_en=3'b011 -> cycle 0: stall_id=1, take_branch=0. Cycle 1: flags=010, ex_flag_en=0 -> taken, target=0x000C.
3. B OV with ex_flag_en=3'b001 (XOR writes Z only) -> no stall; V=0 -> not taken, br_cnt increments, taken_cnt unchanged.
4. BR always, rs_data=0xBEEF -> take_branch=1, target=0xBEEF. B with pc_plus2=0xFFFE, imm9=0x001 -> target=0x0000 (wrap).
5. HLT in ID -> stall_id=1 next 4 cycles; halted=1 on the 4th cycle after HLT and stays set. rst asserted in cycle 2 of the drain -> next cycle halted=0, FSM=RUN, counters 0.
6. Preload 0xFFFF taken branches (force or long run) -> one more taken B leaves br_cnt and taken_cnt at 0xFFFF.
